// File: rtl/memoria_dados_resp_pkg.sv
// Shared definitions for the data-memory responder: FSM state encoding and default word width.
package memoria_dados_resp_pkg;

  localparam int DATA_W_DEF = 32;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ESPERA   = 2'd1,
    RESPOSTA = 2'd2
  } estado_t;

  function automatic logic desalinhado(input logic [1:0] lsb);
    return lsb != 2'b00;
  endfunction

endpackage

// File: rtl/memoria_dados_array.sv
// Synchronous single-port RAM; rdata updates only on enabled reads, so it holds the last load result.
module memoria_dados_array #(
  parameter int DATA_W    = 32,
  parameter int ADDR_BITS = 8
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 en,
  input  logic                 we,
  input  logic [ADDR_BITS-1:0] addr,
  input  logic [DATA_W-1:0]    wdata,
  output logic [DATA_W-1:0]    rdata
);

  logic [DATA_W-1:0] mem [0:(1<<ADDR_BITS)-1];

  always_ff @(posedge clock) begin
    if (en && we) mem[addr] <= wdata;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)        rdata <= '0;
    else if (en && !we)  rdata <= mem[addr];
  end

endmodule

// File: rtl/memoria_dados_resp.sv
// Multi-cycle data-memory responder: accepts a load/store from IDLE, waits WAIT_CYCLES, then
// completes in RESPOSTA with a one-cycle pronto; stall freezes the pipeline while the access is pending.
module memoria_dados_resp
  import memoria_dados_resp_pkg::*;
#(
  parameter int DATA_W      = DATA_W_DEF,
  parameter int ADDR_BITS   = 8,
  parameter int WAIT_CYCLES = 2
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              memRead,
  input  logic              memWrite,
  input  logic [31:0]       endereco,
  input  logic [DATA_W-1:0] dadoEscrita,
  output logic [DATA_W-1:0] dadoLido,
  output logic              pronto,
  output logic              stall,
  output logic              erroAlinhamento
);

  localparam int CNT_W = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_INI = CNT_W'((WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0);

  estado_t              estado;
  logic [CNT_W-1:0]     contador;
  logic                 op_escrita;
  logic [ADDR_BITS-1:0] idx_cap;
  logic [DATA_W-1:0]    dado_cap;

  logic                 pedido, conflito, aceita, vai_resposta;
  logic                 ram_we;
  logic [ADDR_BITS-1:0] ram_addr, idx_in;
  logic [DATA_W-1:0]    ram_wdata;
  logic                 unused_alto;

  // Upper address bits are deliberately ignored: addresses alias modulo depth.
  assign unused_alto = ^endereco[31:ADDR_BITS+2];
  assign idx_in      = endereco[ADDR_BITS+1:2];

  assign pedido       = memRead | memWrite;
  assign conflito     = (memRead & memWrite) | desalinhado(endereco[1:0]);
  assign aceita       = (estado == IDLE) && pedido && !conflito;
  assign vai_resposta = ((estado == ESPERA) && (contador == '0)) ||
                        (aceita && (WAIT_CYCLES == 0));

  // With zero wait states the RAM is hit on the accept edge, before the capture registers load.
  assign ram_we    = (estado == IDLE) ? memWrite    : op_escrita;
  assign ram_addr  = (estado == IDLE) ? idx_in      : idx_cap;
  assign ram_wdata = (estado == IDLE) ? dadoEscrita : dado_cap;

  assign stall = reset_n && ((estado == ESPERA) || aceita);

  memoria_dados_array #(
    .DATA_W    (DATA_W),
    .ADDR_BITS (ADDR_BITS)
  ) u_array (
    .clock   (clock),
    .reset_n (reset_n),
    .en      (vai_resposta),
    .we      (ram_we),
    .addr    (ram_addr),
    .wdata   (ram_wdata),
    .rdata   (dadoLido)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      estado          <= IDLE;
      contador        <= '0;
      op_escrita      <= 1'b0;
      idx_cap         <= '0;
      dado_cap        <= '0;
      pronto          <= 1'b0;
      erroAlinhamento <= 1'b0;
    end else begin
      pronto          <= vai_resposta;
      erroAlinhamento <= 1'b0;
      case (estado)
        IDLE: begin
          if (pedido && conflito) begin
            erroAlinhamento <= 1'b1;
          end else if (pedido) begin
            op_escrita <= memWrite;
            idx_cap    <= idx_in;
            dado_cap   <= dadoEscrita;
            if (WAIT_CYCLES == 0) begin
              estado <= RESPOSTA;
            end else begin
              estado   <= ESPERA;
              contador <= CNT_INI;
            end
          end
        end
        ESPERA: begin
          if (contador == '0) estado <= RESPOSTA;
          else                contador <= contador - 1'b1;
        end
        RESPOSTA: estado <= IDLE;
        default:  estado <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_memoria_dados_resp.sv
// Bench for memoria_dados_resp: directed table, reset-abort sequence, random accesses vs. a word-array model, zero-wait variant.
module tb_memoria_dados_resp;

  localparam int WAIT = 2;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        memRead, memWrite;
  logic [31:0] endereco, dadoEscrita, dadoLido;
  logic        pronto, stall, erroAlinhamento;

  logic        rd0, wr0;
  logic [31:0] addr0, wd0, dado0;
  logic        pronto0, stall0, erro0;

  int checks   = 0;
  int failures = 0;

  always #5 clock = ~clock;

  memoria_dados_resp #(.DATA_W(32), .ADDR_BITS(8), .WAIT_CYCLES(WAIT)) dut (
    .clock(clock), .reset_n(reset_n), .memRead(memRead), .memWrite(memWrite),
    .endereco(endereco), .dadoEscrita(dadoEscrita), .dadoLido(dadoLido),
    .pronto(pronto), .stall(stall), .erroAlinhamento(erroAlinhamento)
  );

  memoria_dados_resp #(.DATA_W(32), .ADDR_BITS(4), .WAIT_CYCLES(0)) dut0 (
    .clock(clock), .reset_n(reset_n), .memRead(rd0), .memWrite(wr0),
    .endereco(addr0), .dadoEscrita(wd0), .dadoLido(dado0),
    .pronto(pronto0), .stall(stall0), .erroAlinhamento(erro0)
  );

  typedef struct {
    logic        rd;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] data;
    logic        exp_err;
    logic [31:0] exp_dado;
  } vec_t;

  vec_t        tab [10];
  logic [31:0] mdl [256];
  logic [31:0] last;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%h expected=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // Called just after a rising edge with the DUT idle; returns just after a rising edge with it idle again.
  task automatic access(input logic rd, input logic wr, input logic [31:0] addr,
                        input logic [31:0] data, input logic exp_err, input logic [31:0] exp_dado);
    memRead = rd; memWrite = wr; endereco = addr; dadoEscrita = data;
    @(negedge clock);
    chk("stall_accept", {31'd0, stall}, {31'd0, !exp_err});
    chk("pronto_accept", {31'd0, pronto}, 32'd0);
    @(posedge clock); #1;
    memRead = 1'b0; memWrite = 1'b0; endereco = $urandom; dadoEscrita = $urandom;
    if (exp_err) begin
      @(negedge clock);
      chk("erro_pulse", {31'd0, erroAlinhamento}, 32'd1);
      chk("stall_err", {31'd0, stall}, 32'd0);
      chk("dado_err", dadoLido, exp_dado);
      @(posedge clock); #1;
      @(negedge clock);
      chk("erro_end", {31'd0, erroAlinhamento}, 32'd0);
      @(posedge clock); #1;
    end else begin
      for (int i = 0; i < WAIT; i++) begin
        @(negedge clock);
        chk("stall_wait", {31'd0, stall}, 32'd1);
        chk("pronto_wait", {31'd0, pronto}, 32'd0);
        @(posedge clock); #1;
      end
      @(negedge clock);
      chk("pronto_resp", {31'd0, pronto}, 32'd1);
      chk("stall_resp", {31'd0, stall}, 32'd0);
      chk("erro_resp", {31'd0, erroAlinhamento}, 32'd0);
      chk("dado_resp", dadoLido, exp_dado);
      @(posedge clock); #1;
      @(negedge clock);
      chk("pronto_idle", {31'd0, pronto}, 32'd0);
      @(posedge clock); #1;
    end
  endtask

  initial begin
    logic [3:0]  idx4;
    logic [31:0] hi, addr, data;
    logic        rd, wr, err;
    int          r;

    tab[0] = '{1'b0, 1'b1, 32'h0000_0004, 32'hDEAD_BEEF, 1'b0, 32'h0000_0000};
    tab[1] = '{1'b1, 1'b0, 32'h0000_0004, 32'h0000_0000, 1'b0, 32'hDEAD_BEEF};
    tab[2] = '{1'b1, 1'b0, 32'h0000_0006, 32'h0000_0000, 1'b1, 32'hDEAD_BEEF};
    tab[3] = '{1'b0, 1'b1, 32'h0000_0008, 32'h1234_5678, 1'b0, 32'hDEAD_BEEF};
    tab[4] = '{1'b1, 1'b1, 32'h0000_0008, 32'hFFFF_FFFF, 1'b1, 32'hDEAD_BEEF};
    tab[5] = '{1'b1, 1'b0, 32'h0000_0008, 32'h0000_0000, 1'b0, 32'h1234_5678};
    tab[6] = '{1'b0, 1'b1, 32'h0000_0000, 32'h0000_0011, 1'b0, 32'h1234_5678};
    tab[7] = '{1'b0, 1'b1, 32'h0000_0400, 32'h0000_0022, 1'b0, 32'h1234_5678};
    tab[8] = '{1'b1, 1'b0, 32'h0000_0000, 32'h0000_0000, 1'b0, 32'h0000_0022};
    tab[9] = '{1'b1, 1'b0, 32'h0000_0404, 32'h0000_0000, 1'b0, 32'hDEAD_BEEF};

    memRead = 0; memWrite = 0; endereco = 0; dadoEscrita = 0;
    rd0 = 0; wr0 = 0; addr0 = 0; wd0 = 0;
    reset_n = 1'b0;
    #2;
    chk("rst_dado", dadoLido, 32'd0);
    chk("rst_pronto", {31'd0, pronto}, 32'd0);
    chk("rst_stall", {31'd0, stall}, 32'd0);
    chk("rst_erro", {31'd0, erroAlinhamento}, 32'd0);
    @(posedge clock); #1;
    reset_n = 1'b1;
    @(posedge clock); #1;

    for (int v = 0; v < 10; v++)
      access(tab[v].rd, tab[v].wr, tab[v].addr, tab[v].data, tab[v].exp_err, tab[v].exp_dado);

    // Store aborted by reset mid-wait must never reach the array.
    access(1'b0, 1'b1, 32'h10, 32'hA5A5_A5A5, 1'b0, 32'hDEAD_BEEF);
    memWrite = 1'b1; endereco = 32'h10; dadoEscrita = 32'h0000_0BAD;
    @(posedge clock); #1;
    memWrite = 1'b0;
    @(negedge clock);
    chk("abort_stall", {31'd0, stall}, 32'd1);
    #1 reset_n = 1'b0;
    #1;
    chk("abort_dado", dadoLido, 32'd0);
    chk("abort_pronto", {31'd0, pronto}, 32'd0);
    chk("abort_stall0", {31'd0, stall}, 32'd0);
    chk("abort_erro", {31'd0, erroAlinhamento}, 32'd0);
    @(posedge clock); #1;
    reset_n = 1'b1;
    @(posedge clock); #1;
    access(1'b1, 1'b0, 32'h10, 32'h0, 1'b0, 32'hA5A5_A5A5);
    last = 32'hA5A5_A5A5;

    // Random traffic on word indices 0..15 with random aliasing high bits.
    for (int i = 0; i < 16; i++) begin
      mdl[i] = $urandom;
      access(1'b0, 1'b1, 32'(i) << 2, mdl[i], 1'b0, last);
    end
    for (int n = 0; n < 60; n++) begin
      r    = int'($urandom_range(0, 9));
      idx4 = 4'($urandom_range(0, 15));
      hi   = $urandom;
      data = $urandom;
      addr = {hi[21:0], 4'b0000, idx4, 2'b00};
      if (r == 0) addr[1:0] = 2'($urandom_range(1, 3));
      rd  = (r <= 4) || (r == 9);
      wr  = (r >= 5);
      err = (rd && wr) || (addr[1:0] != 2'b00);
      if (!err) begin
        if (wr) mdl[idx4] = data;
        else    last = mdl[idx4];
      end
      access(rd, wr, addr, data, err, last);
    end

    // Zero wait states: one store, then a held load completes every second cycle.
    wr0 = 1'b1; addr0 = 32'h0C; wd0 = 32'h77;
    @(negedge clock);
    chk("w0_stall_accept", {31'd0, stall0}, 32'd1);
    chk("w0_pronto_accept", {31'd0, pronto0}, 32'd0);
    @(posedge clock); #1;
    wr0 = 1'b0;
    @(negedge clock);
    chk("w0_pronto_store", {31'd0, pronto0}, 32'd1);
    chk("w0_stall_store", {31'd0, stall0}, 32'd0);
    @(posedge clock); #1;
    rd0 = 1'b1;
    for (int k = 0; k < 8; k++) begin
      @(negedge clock);
      chk("w0_stall_held", {31'd0, stall0}, {31'd0, (k % 2) == 0});
      chk("w0_pronto_held", {31'd0, pronto0}, {31'd0, (k % 2) == 1});
      if ((k % 2) == 1) chk("w0_dado_held", dado0, 32'h77);
      @(posedge clock); #1;
    end
    rd0 = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
